// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, imem handshake, skid buffer, IF/ID.
// Define IF_JAL_PREDICT_EN to follow JAL targets at fetch time.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    KILL
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic        req_nx;
  logic [31:0] addr_nx;
  logic [31:0] inst_nx;
  logic [31:0] ipc_nx;
  logic        valid_nx;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_valid;
  logic [31:0] buf_inst_nx;
  logic [31:0] buf_pc_nx;
  logic        buf_valid_nx;
  logic        xfer;
  logic [31:0] tgt;
  logic [31:0] seq_pc;

  assign xfer = imem_req && imem_ready;
  assign tgt  = {redirect_pc[31:2], 2'b00};

`ifdef IF_JAL_PREDICT_EN
  logic [31:0] jimm;
  logic        is_jal;

  assign jimm = {{12{imem_rdata[31]}},
                 imem_rdata[19:12],
                 imem_rdata[20],
                 imem_rdata[30:21],
                 1'b0};
  assign is_jal = imem_rdata[6:0] == 7'b1101111;
  // Halfword targets are masked so imem_addr stays word-aligned.
  assign seq_pc = is_jal ? ((pc + jimm) & ~32'd3)
                         : pc + 32'd4;
`else
  assign seq_pc = pc + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      buf_inst    <= NOP_INST;
      buf_pc      <= '0;
      buf_valid   <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      if_id_inst  <= inst_nx;
      if_id_pc    <= ipc_nx;
      if_id_valid <= valid_nx;
      buf_inst    <= buf_inst_nx;
      buf_pc      <= buf_pc_nx;
      buf_valid   <= buf_valid_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    req_nx       = imem_req;
    addr_nx      = imem_addr;
    inst_nx      = if_id_inst;
    ipc_nx       = if_id_pc;
    valid_nx     = if_id_valid;
    buf_inst_nx  = buf_inst;
    buf_pc_nx    = buf_pc;
    buf_valid_nx = buf_valid;
    if (redirect_valid) begin
      inst_nx      = NOP_INST;
      valid_nx     = 1'b0;
      buf_valid_nx = 1'b0;
      pc_nx        = tgt;
      // An outstanding request cannot be withdrawn; pc holds the target.
      if (imem_req && !xfer) begin
        state_nx = KILL;
      end else begin
        state_nx = FETCH;
        req_nx   = 1'b1;
        addr_nx  = tgt;
      end
    end else begin
      unique case (state)
        BOOT: begin
          state_nx = FETCH;
          req_nx   = 1'b1;
          addr_nx  = pc;
        end
        FETCH: begin
          if (xfer && stall) begin
            buf_inst_nx  = imem_rdata;
            buf_pc_nx    = pc;
            buf_valid_nx = 1'b1;
            pc_nx        = seq_pc;
            req_nx       = 1'b0;
            state_nx     = HOLD;
          end else if (xfer) begin
            inst_nx  = imem_rdata;
            ipc_nx   = pc;
            valid_nx = 1'b1;
            pc_nx    = seq_pc;
            addr_nx  = seq_pc;
          end else if (!stall) begin
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_nx      = buf_inst;
            ipc_nx       = buf_pc;
            valid_nx     = buf_valid;
            buf_valid_nx = 1'b0;
            req_nx       = 1'b1;
            addr_nx      = pc;
            state_nx     = FETCH;
          end
        end
        KILL: begin
          if (xfer) begin
            addr_nx  = pc;
            state_nx = FETCH;
          end else if (!stall) begin
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

endmodule
